// File: rtl/ifetch_queue_if.sv
// Fetch-to-decode bundle for ifetch_queue: the imem port, the redirect input, the decode handshake and status.
// IFETCH_MISALIGN_CHK_EN adds the misalign status bit.
interface ifetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [31:0]      imem_addr;
    logic [31:0]      imem_rd;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             instr_valid;
    logic [31:0]      instr;
    logic [31:0]      instr_pc;
    logic             instr_ready;
    logic             fetch_done;
    logic [LVL_W-1:0] fifo_level;
    logic [1:0]       dbg_state;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic             misalign;
`endif

    // Handshake: decode takes the head on a rising clock edge where instr_valid and instr_ready
    // are both high. instr_valid, instr and instr_pc depend only on state, never on instr_ready.
    modport master (
`ifdef IFETCH_MISALIGN_CHK_EN
        output misalign,
`endif
        output imem_addr, input imem_rd,
        input redirect_valid, input redirect_pc,
        output instr_valid, output instr, output instr_pc, input instr_ready,
        output fetch_done, output fifo_level, output dbg_state
    );

    modport slave (
`ifdef IFETCH_MISALIGN_CHK_EN
        input misalign,
`endif
        input imem_addr, output imem_rd,
        output redirect_valid, output redirect_pc,
        input instr_valid, input instr, input instr_pc, output instr_ready,
        input fetch_done, input fifo_level, input dbg_state
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the PC, captures imem words into a DEPTH-entry FIFO for decode, and flushes on redirect.
// IFETCH_MISALIGN_CHK_EN enables the misaligned-redirect HALT state and the misalign output.
module ifetch_queue #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int          IMEM_BYTES = 108
) (
    input logic           clk,
    input logic           reset,
    ifetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [32:0] LIMIT = 33'(IMEM_BYTES);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DONE  = 2'd1
`ifdef IFETCH_MISALIGN_CHK_EN
        , S_HALT  = 2'd2
`endif
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           fifo_q [DEPTH];
    entry_t           fifo_d [DEPTH];
`ifdef IFETCH_MISALIGN_CHK_EN
    logic             misalign_q, misalign_d;
`endif

    logic        head_valid;
    logic        pop;
    logic        push;
    logic        take_redirect;
    logic [31:0] target;

    // 33-bit compare so an address near 2^32 cannot wrap back into range.
    function automatic logic in_range(input logic [31:0] a);
        return ({1'b0, a} + 33'd4) <= LIMIT;
    endfunction

    always_comb begin
        head_valid = (count_q != '0);
        pop        = head_valid & bus.instr_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push       = (state_q == S_FETCH) && !((count_q == CNT_W'(DEPTH)) && !pop) && in_range(pc_q);

        target = bus.redirect_pc;
`ifdef IFETCH_MISALIGN_CHK_EN
        take_redirect = bus.redirect_valid && (state_q != S_HALT);
`else
        take_redirect = bus.redirect_valid;
        target[1:0]   = 2'b00;
`endif

        state_d = state_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        fifo_d  = fifo_q;
`ifdef IFETCH_MISALIGN_CHK_EN
        misalign_d = misalign_q;
`endif

        if (take_redirect) begin
            // Flush wins over any pop or push in the same cycle.
            pc_d    = target;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            state_d = in_range(target) ? S_FETCH : S_DONE;
`ifdef IFETCH_MISALIGN_CHK_EN
            if (target[1:0] != 2'b00) begin
                state_d    = S_HALT;
                misalign_d = 1'b1;
            end
`endif
        end else begin
            if (push) begin
                fifo_d[tail_q] = '{pc: pc_q, word: bus.imem_rd};
                tail_d         = tail_q + 1'b1;
                pc_d           = pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if ((state_q == S_FETCH) && !in_range(pc_q)) begin
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
`ifdef IFETCH_MISALIGN_CHK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
`ifdef IFETCH_MISALIGN_CHK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Storage needs no reset: count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_valid ? fifo_q[head_q].word : 32'h0;
    assign bus.instr_pc    = head_valid ? fifo_q[head_q].pc : 32'h0;
    assign bus.fetch_done  = (state_q == S_DONE);
    assign bus.fifo_level  = count_q;
    assign bus.dbg_state   = state_q;
`ifdef IFETCH_MISALIGN_CHK_EN
    assign bus.misalign    = misalign_q;
`endif
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a 108-byte imem model; covers both IFETCH_MISALIGN_CHK_EN builds.
module tb_ifetch_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [31:0] mem [27];
    logic [31:0] exp_q [$];
    logic [31:0] e_pc;
    logic [31:0] last_pc;
    logic [31:0] last_instr;

    ifetch_queue_if #(.DEPTH(4)) bus ();

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .IMEM_BYTES(108)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (bus.imem_addr < 32'd108) bus.imem_rd = mem[bus.imem_addr[6:2]];
        else                         bus.imem_rd = 32'h0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.instr_ready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = target;
        step();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 27; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20) | (32'(i) << 7);
        mem[0]  = 32'h00500113;
        mem[1]  = 32'h00c00193;
        mem[16] = 32'h008001ef;
        mem[26] = 32'h00210063;

        // Reset state
        do_reset();
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_level", 32'(bus.fifo_level), 32'd0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_done", 32'(bus.fetch_done), 32'd0);
        check("rst_instr", bus.instr, 32'h0);
`ifdef IFETCH_MISALIGN_CHK_EN
        check("rst_misalign", 32'(bus.misalign), 32'd0);
`endif

        // 1: first-fetch latency and streaming
        bus.instr_ready = 1'b1;
        step();
        check("t1_valid", 32'(bus.instr_valid), 32'd1);
        check("t1_instr0", bus.instr, 32'h00500113);
        check("t1_pc0", bus.instr_pc, 32'h0);
        step();
        check("t1_instr1", bus.instr, 32'h00c00193);
        check("t1_pc1", bus.instr_pc, 32'h4);

        // 2: mid-run reset clears, then fill with decode stalled
        do_reset();
        check("t2_rst_level", 32'(bus.fifo_level), 32'd0);
        check("t2_rst_addr", bus.imem_addr, 32'h0);
        step(6);
        check("t2_level", 32'(bus.fifo_level), 32'd4);
        check("t2_addr", bus.imem_addr, 32'h10);
        check("t2_head", bus.instr, 32'h00500113);

        // 3: full FIFO with one pop: push and pop together
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        check("t3_level", 32'(bus.fifo_level), 32'd4);
        check("t3_head", bus.instr, 32'h00c00193);
        check("t3_addr", bus.imem_addr, 32'h14);

        // 4: redirect with a simultaneous pop
        bus.instr_ready = 1'b1;
        redirect(32'h40);
        bus.instr_ready = 1'b0;
        check("t4_level", 32'(bus.fifo_level), 32'd0);
        check("t4_valid", 32'(bus.instr_valid), 32'd0);
        check("t4_addr", bus.imem_addr, 32'h40);
        step();
        check("t4_instr", bus.instr, 32'h008001ef);
        check("t4_pc", bus.instr_pc, 32'h40);

        // 5: free-run to the end of imem, scoreboarding every delivered entry
        for (int a = 32'h40; a <= 32'h68; a += 4) exp_q.push_back(32'(a));
        last_pc = 32'hdead_beef;
        last_instr = 32'hdead_beef;
        bus.instr_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (bus.instr_valid) begin
                if (exp_q.size() == 0) begin
                    check("t5_extra_pc", bus.instr_pc, 32'hffff_ffff);
                end else begin
                    e_pc = exp_q.pop_front();
                    check("t5_pc", bus.instr_pc, e_pc);
                    check("t5_instr", bus.instr, mem[e_pc[6:2]]);
                end
                last_pc = bus.instr_pc;
                last_instr = bus.instr;
            end
            step();
        end
        check("t5_left", 32'(exp_q.size()), 32'd0);
        check("t5_last_pc", last_pc, 32'h68);
        check("t5_last_instr", last_instr, 32'h00210063);
        check("t5_done", 32'(bus.fetch_done), 32'd1);
        check("t5_level", 32'(bus.fifo_level), 32'd0);
        step(3);
        check("t5_stay_empty", 32'(bus.fifo_level), 32'd0);

        // 6: misaligned redirect
        bus.instr_ready = 1'b0;
        redirect(32'h42);
`ifdef IFETCH_MISALIGN_CHK_EN
        check("t6_misalign", 32'(bus.misalign), 32'd1);
        check("t6_addr", bus.imem_addr, 32'h42);
        step(3);
        check("t6_level", 32'(bus.fifo_level), 32'd0);
        check("t6_done", 32'(bus.fetch_done), 32'd0);
        redirect(32'h0);
        step(2);
        check("t6_halt_hold", 32'(bus.fifo_level), 32'd0);
        check("t6_halt_misalign", 32'(bus.misalign), 32'd1);
        do_reset();
        check("t6_rst_misalign", 32'(bus.misalign), 32'd0);
`else
        check("t6_addr", bus.imem_addr, 32'h40);
        check("t6_done", 32'(bus.fetch_done), 32'd0);
        step();
        check("t6_pc", bus.instr_pc, 32'h40);
        check("t6_instr", bus.instr, 32'h008001ef);
        do_reset();
`endif

        // 7: redirect targets at and beyond the imem boundary
        redirect(32'hffff_fffc);
        check("t7_wrap_done", 32'(bus.fetch_done), 32'd1);
        check("t7_wrap_addr", bus.imem_addr, 32'hffff_fffc);
        step(2);
        check("t7_wrap_level", 32'(bus.fifo_level), 32'd0);
        redirect(32'h68);
        check("t7_edge_done0", 32'(bus.fetch_done), 32'd0);
        step();
        check("t7_edge_level", 32'(bus.fifo_level), 32'd1);
        check("t7_edge_addr", bus.imem_addr, 32'h6c);
        step();
        check("t7_edge_done1", 32'(bus.fetch_done), 32'd1);
        check("t7_edge_hold", 32'(bus.fifo_level), 32'd1);
        check("t7_edge_pc", bus.instr_pc, 32'h68);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
